fifo_stream_reader: RTL

//  Pop-side companion to sync_fifo. Drains the FIFO through its pop/rd_data

---
 rtl/fifo_pkg.sv | 18 +
 rtl/stream_buf2.sv | 66 ++++++
 rtl/fifo_stream_reader.sv | 72 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo read-port ecosystem: default word width,
// the read-port bundle type and a fill-level helper used by the pop-side logic.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef struct packed {
    logic                      pop;
    logic                      empty;
    logic [DATA_WIDTH_DEF-1:0] rd_data;
  } fifo_rd_if_t;

  // Words already committed to the reader: buffered plus the one still in flight.
  function automatic logic [2:0] fill_level(input logic [1:0] occ, input logic inflight);
    return {1'b0, occ} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry register buffer with head/tail pointers; head is presented
// combinationally, tail is written on wr_en, flush empties it at once.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
  logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      occ_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_ptr_q) mem1_d = wr_data;
        else          mem0_d = wr_data;
        wr_ptr_d = !wr_ptr_q;
      end
      if (rd_en) rd_ptr_d = !rd_ptr_q;
      // Simultaneous write and read leaves occupancy unchanged.
      occ_d = occ_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = rd_ptr_q ? mem1_q : mem0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync_fifo read port onto a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a two-entry buffer for full throughput.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  logic                 inflight_q, inflight_d;
  logic                 discard_q, discard_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic [1:0]           occ;
  logic                 deq;
  logic                 capture;

  assign m_valid = (occ != 2'd0);
  assign deq     = m_valid & m_ready & !flush;
  // A dequeue this cycle frees a slot, so pop may look through m_ready.
  assign fifo_pop = !reset & !fifo_empty & !flush &
                    (fill_level(occ, inflight_q) < (3'd2 + {2'b00, deq}));
  assign capture  = inflight_q & !discard_q & !flush;

  always_comb begin
    inflight_d = fifo_pop;
    discard_d  = flush & inflight_q;
    beat_cnt_d = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, deq};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (capture),
    .wr_data   (fifo_rd_data),
    .rd_en     (deq),
    .occ       (occ),
    .head_data (m_data)
  );

  assign beat_cnt = beat_cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    fill_level(occ, inflight_q) <= 3'd2);

endmodule
